mandel_iter_ctrl: RTL and testbench

- Per-pixel iteration controller sitting directly upstream of the Mandelbrot divergence/iteration stage.
- Accepts one pixel constant (c_re, c_im) plus a pixel tag over a valid/ready handshake.
- Drives the stage's load strobe and constant inputs, then counts iteration cycles until the stage flags divergence or MAX_ITER is reached.
- Returns the escape count and tag to the downstream colour/framebuffer writer over a second valid/ready handshake.

---
 rtl/mandel_iter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mandel_iter_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mandel_iter_ctrl.sv
// -----------------------------------------------------------------------------
// mandel_iter_ctrl
//   Per-pixel iteration controller for the Mandelbrot divergence stage.
//   It accepts one pixel constant (c_re, c_im) and a tag, then pulses core_ld
//   for one cycle. It counts iteration cycles until the stage reports
//   divergence or MAX_ITER is reached. It then returns the escape count and the
//   tag to the downstream writer.
//
//   Optional feature macro: MANDEL_ITER_STATS_EN
//     When defined, the stat_pixels and stat_escaped output ports exist.
//     They are 32-bit wrapping counters of accepted results and of accepted
//     escaped results.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   request handshake; in_c_re, in_c_im, in_tag payload
//   core_ld             one-cycle load/clear strobe to the iteration stage
//   core_a, core_b      latched c_re / c_im, held until the next accept
//   core_diverged       divergence flag from the stage (used in ITER only)
//   out_valid/out_ready result handshake; out_count, out_escaped, out_tag
// -----------------------------------------------------------------------------
module mandel_iter_ctrl #(
  parameter int DATA_W   = 32,
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8,
  parameter int TAG_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_c_re,
  input  logic [DATA_W-1:0] in_c_im,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              core_ld,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  input  logic              core_diverged,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] out_count,
  output logic              out_escaped,
  output logic [TAG_W-1:0]  out_tag
`ifdef MANDEL_ITER_STATS_EN
  ,
  output logic [31:0]       stat_pixels,
  output logic [31:0]       stat_escaped
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t            state_q, state_d;
  logic [ITER_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] core_a_q, core_a_d;
  logic [DATA_W-1:0] core_b_q, core_b_d;
  logic [ITER_W-1:0] out_count_q, out_count_d;
  logic              out_escaped_q, out_escaped_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
`ifdef MANDEL_ITER_STATS_EN
  logic [31:0]       stat_pixels_q, stat_pixels_d;
  logic [31:0]       stat_escaped_q, stat_escaped_d;
`endif

  localparam logic [ITER_W-1:0] LAST_CNT = ITER_W'(MAX_ITER - 1);
  localparam logic [ITER_W-1:0] MAX_CNT  = ITER_W'(MAX_ITER);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    core_a_d      = core_a_q;
    core_b_d      = core_b_q;
    out_count_d   = out_count_q;
    out_escaped_d = out_escaped_q;
    out_tag_d     = out_tag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          core_a_d  = in_c_re;
          core_b_d  = in_c_im;
          out_tag_d = in_tag;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        count_d = '0;
        state_d = ITER;
      end
      ITER: begin
        // Divergence is checked first, so it wins when it coincides with the limit.
        if (core_diverged) begin
          out_count_d   = count_q;
          out_escaped_d = 1'b1;
          state_d       = DONE;
        end else if (count_q == LAST_CNT) begin
          out_count_d   = MAX_CNT;
          out_escaped_d = 1'b0;
          state_d       = DONE;
        end else begin
          count_d = count_q + ITER_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MANDEL_ITER_STATS_EN
  always_comb begin
    stat_pixels_d  = stat_pixels_q;
    stat_escaped_d = stat_escaped_q;
    if (state_q == DONE && out_ready) begin
      stat_pixels_d = stat_pixels_q + 32'd1;
      if (out_escaped_q) stat_escaped_d = stat_escaped_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= '0;
      core_a_q       <= '0;
      core_b_q       <= '0;
      out_count_q    <= '0;
      out_escaped_q  <= 1'b0;
      out_tag_q      <= '0;
`ifdef MANDEL_ITER_STATS_EN
      stat_pixels_q  <= '0;
      stat_escaped_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      core_a_q       <= core_a_d;
      core_b_q       <= core_b_d;
      out_count_q    <= out_count_d;
      out_escaped_q  <= out_escaped_d;
      out_tag_q      <= out_tag_d;
`ifdef MANDEL_ITER_STATS_EN
      stat_pixels_q  <= stat_pixels_d;
      stat_escaped_q <= stat_escaped_d;
`endif
    end
  end

  // Handshake and strobe outputs are pure decodes of the registered state.
  assign in_ready    = (state_q == IDLE);
  assign core_ld     = (state_q == LOAD);
  assign out_valid   = (state_q == DONE);
  assign core_a      = core_a_q;
  assign core_b      = core_b_q;
  assign out_count   = out_count_q;
  assign out_escaped = out_escaped_q;
  assign out_tag     = out_tag_q;
`ifdef MANDEL_ITER_STATS_EN
  assign stat_pixels  = stat_pixels_q;
  assign stat_escaped = stat_escaped_q;
`endif

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mandel_iter_ctrl
//   Randomized bench for mandel_iter_ctrl. The reference model works per pixel.
//   A pixel told to diverge on ITER cycle k escapes with count k when
//   k < MAX_ITER. Otherwise it stops with count MAX_ITER, not escaped.
//   The result appears 3 + min(k, MAX_ITER-1) cycles after the accept edge.
//   The stub drives core_diverged from that timeline. It injects noise outside
//   ITER cycles, and also during IDLE and DONE, where the flag must be ignored.
// -----------------------------------------------------------------------------
module tb_mandel_iter_ctrl;
  localparam int DATA_W   = 32;
  localparam int MAX_ITER = 255;
  localparam int ITER_W   = 8;
  localparam int TAG_W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_c_re = '0;
  logic [DATA_W-1:0] in_c_im = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              core_ld;
  logic [DATA_W-1:0] core_a;
  logic [DATA_W-1:0] core_b;
  logic              core_diverged = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ITER_W-1:0] out_count;
  logic              out_escaped;
  logic [TAG_W-1:0]  out_tag;
`ifdef MANDEL_ITER_STATS_EN
  logic [31:0]       stat_pixels;
  logic [31:0]       stat_escaped;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_pix = 0;
  int exp_esc = 0;

  mandel_iter_ctrl #(
    .DATA_W(DATA_W), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_c_re(in_c_re), .in_c_im(in_c_im), .in_tag(in_tag),
    .core_ld(core_ld), .core_a(core_a), .core_b(core_b),
    .core_diverged(core_diverged),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_escaped(out_escaped), .out_tag(out_tag)
`ifdef MANDEL_ITER_STATS_EN
    , .stat_pixels(stat_pixels), .stat_escaped(stat_escaped)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Runs one pixel starting at a negedge with the DUT idle. k is the ITER
  // cycle on which the stub asserts divergence. bp is the number of DONE
  // cycles held off by out_ready=0. hold keeps in_valid high with decoy data
  // while the controller is busy.
  task automatic run_pixel(input int k, input int bp, input bit hold);
    logic [DATA_W-1:0] cre, cim;
    logic [TAG_W-1:0]  tg;
    logic [ITER_W-1:0] e_cnt;
    logic              e_esc;
    int                lat, last, first_vld;
    bit                ld_ok, rdy_ok, a_ok, hold_ok;
    logic [ITER_W-1:0] got_cnt;
    logic              got_esc;
    logic [TAG_W-1:0]  got_tag;
    cre = $urandom; cim = $urandom; tg = TAG_W'($urandom);
    if (k < MAX_ITER) begin e_cnt = ITER_W'(k); e_esc = 1'b1; end
    else              begin e_cnt = ITER_W'(MAX_ITER); e_esc = 1'b0; end
    lat  = 3 + ((k < MAX_ITER - 1) ? k : MAX_ITER - 1);
    last = lat + bp;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_c_re = cre; in_c_im = cim; in_tag = tg;
    core_diverged = 1'($urandom);
    out_ready = 1'($urandom);
    @(posedge clk);
    ld_ok = 1; rdy_ok = 1; a_ok = 1; hold_ok = 1; first_vld = -1;
    got_cnt = '0; got_esc = 1'b0; got_tag = '0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (core_ld !== (c == 1)) ld_ok = 0;
      if (in_ready !== 1'b0) rdy_ok = 0;
      if (core_a !== cre || core_b !== cim) a_ok = 0;
      if (out_valid === 1'b1 && first_vld < 0) begin
        first_vld = c; got_cnt = out_count; got_esc = out_escaped; got_tag = out_tag;
      end
      if (c >= lat && (out_valid !== 1'b1 || out_count !== got_cnt ||
                       out_escaped !== got_esc || out_tag !== got_tag)) hold_ok = 0;
      // Stimulus for cycle c.
      in_valid = hold;
      in_c_re = $urandom; in_c_im = $urandom; in_tag = TAG_W'($urandom);
      if (c >= 2 && c < lat) core_diverged = (c - 2 == k);
      else                   core_diverged = 1'($urandom);
      if (c < lat)       out_ready = 1'($urandom);
      else if (c < last) out_ready = 1'b0;
      else               out_ready = 1'b1;
    end
    @(negedge clk);
    check("core_ld_only_load", 64'(ld_ok), 64'd1);
    check("in_ready_busy_low", 64'(rdy_ok), 64'd1);
    check("core_ab_held", 64'(a_ok), 64'd1);
    check("first_valid_cycle", 64'(first_vld), 64'(lat));
    check("out_count", 64'(got_cnt), 64'(e_cnt));
    check("out_escaped", 64'(got_esc), 64'(e_esc));
    check("out_tag", 64'(got_tag), 64'(tg));
    check("result_held", 64'(hold_ok), 64'd1);
    check("valid_drop_after_accept", 64'(out_valid), 64'd0);
    exp_pix++;
    if (e_esc) exp_esc++;
    in_valid = 1'b0; out_ready = 1'b0; core_diverged = 1'b0;
  endtask

  initial begin
    int k;
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_core_ld", 64'(core_ld), 64'd0);
    check("rst_data", {out_count, out_escaped, out_tag, core_a[7:0]}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases: early escape, no escape, coincident, minimum latency, backpressure.
    run_pixel(3, 0, 1'b0);
    run_pixel(1000, 0, 1'b0);
    run_pixel(MAX_ITER - 1, 0, 1'b0);
    run_pixel(0, 0, 1'b1);
    run_pixel(2, 10, 1'b1);

    // Reset while iterating: drop rst when the count is 7 (ITER cycle index 7).
    in_valid = 1'b1; in_c_re = $urandom; in_c_im = $urandom; in_tag = 16'h1234;
    @(posedge clk);
    in_valid = 1'b0; core_diverged = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_data", {out_tag, core_a[15:0], out_count, 8'd0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_pix = 0; exp_esc = 0;
    run_pixel(5, 0, 1'b0);

    // Randomized pixels.
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) == 0) k = $urandom_range(0, 10);
      else                           k = $urandom_range(0, 300);
      run_pixel(k, $urandom_range(0, 4), 1'($urandom));
    end

`ifdef MANDEL_ITER_STATS_EN
    check("stat_pixels", 64'(stat_pixels), 64'(exp_pix));
    check("stat_escaped", 64'(stat_escaped), 64'(exp_esc));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
